// File: rtl/xreg_bank_pkg.sv
// Shared SAP-2 index-bank definitions: default datapath width and the update-priority encoding.
// Combinational helper only; no state.
package xreg_bank_pkg;

  localparam int SAP2_WIDTH = 12;

  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_LOAD = 2'd1,
    OP_INC  = 2'd2,
    OP_DEC  = 2'd3
  } xop_e;

  // lslot is the load priority slot (lx, plus llim when the limit is built in);
  // it blocks arithmetic even when only the limit is being loaded.
  function automatic xop_e xop_decode(input logic lx, input logic lslot, input logic pinc,
                                      input logic inx, input logic dex);
    xop_e r;
    r = OP_HOLD;
    if (lx)              r = OP_LOAD;
    else if (lslot)      r = OP_HOLD;
    else if (pinc)       r = OP_INC;
    else if (inx && dex) r = OP_HOLD;
    else if (inx)        r = OP_INC;
    else if (dex)        r = OP_DEC;
    return r;
  endfunction

endpackage

// File: rtl/xreg_bank_if.sv
// Control and flag signals between the SAP-2 controller and the index-register bank.
// Optional XBANK_LIMIT_EN adds llim/il.
interface xreg_bank_if #(
  parameter int NREG = 4
);
  localparam int SEL_W = $clog2(NREG);

  logic [SEL_W-1:0] sel;
  logic             lx;
  logic             ex;
  logic             inx;
  logic             dex;
  logic             pinc;
  logic             im;
  logic             iz;
  logic             iw;
`ifdef XBANK_LIMIT_EN
  logic             llim;
  logic             il;
`endif

  modport master (
    output sel, lx, ex, inx, dex, pinc,
`ifdef XBANK_LIMIT_EN
    output llim,
    input  il,
`endif
    input  im, iz, iw
  );

  modport slave (
    input  sel, lx, ex, inx, dex, pinc,
`ifdef XBANK_LIMIT_EN
    input  llim,
    output il,
`endif
    output im, iz, iw
  );

endinterface

// File: rtl/xreg_cell.sv
// One index register plus sticky wrap flag; optional ring limit under XBANK_LIMIT_EN.
// Latency: update visible one cycle after the edge; no backpressure, op is applied every cycle.
module xreg_cell
  import xreg_bank_pkg::*;
#(
  parameter int WIDTH = SAP2_WIDTH,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  xop_e             op,
  input  logic [WIDTH-1:0] din,
`ifdef XBANK_LIMIT_EN
  input  logic             ldl,
  output logic [WIDTH-1:0] lim,
`endif
  output logic [WIDTH-1:0] q,
  output logic             wrap
);

  localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(STEP);

  // Extra top bit carries the unsigned carry (add) or borrow (subtract).
  logic [WIDTH:0] sum;
  logic [WIDTH:0] dif;

  assign sum = {1'b0, q} + STEP_X;
  assign dif = {1'b0, q} - STEP_X;

  always_ff @(posedge clk) begin
    if (clr) begin
      q    <= '0;
      wrap <= 1'b0;
`ifdef XBANK_LIMIT_EN
      lim  <= '1;
`endif
    end else begin
`ifdef XBANK_LIMIT_EN
      if (ldl) lim <= din;
`endif
      case (op)
        OP_LOAD: begin
          q    <= din;
          wrap <= 1'b0;
        end
        OP_INC: begin
`ifdef XBANK_LIMIT_EN
          if (q == lim) begin
            q    <= '0;
            wrap <= 1'b1;
          end else
`endif
          begin
            q <= sum[WIDTH-1:0];
            if (sum[WIDTH]) wrap <= 1'b1;
          end
        end
        OP_DEC: begin
`ifdef XBANK_LIMIT_EN
          if (q == '0) begin
            q    <= lim;
            wrap <= 1'b1;
          end else
`endif
          begin
            q <= dif[WIDTH-1:0];
            if (dif[WIDTH]) wrap <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/xreg_bank.sv
// Bank of NREG SAP-2 index registers on the shared tristate bus; XBANK_LIMIT_EN adds ring limits.
// Latency: bus drive and flags combinational on sel; register updates land at the next edge.
// Backpressure: none, every control strobe is acted on in the cycle it is presented.
module xreg_bank
  import xreg_bank_pkg::*;
#(
  parameter int WIDTH = SAP2_WIDTH,
  parameter int NREG  = 4,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             clr,
  inout  wire  [WIDTH-1:0] bus,
  xreg_bank_if.slave       ifc
);

  localparam int SEL_W = $clog2(NREG);

  logic [WIDTH-1:0] val [NREG];
  logic [NREG-1:0]  wrap;
  logic [WIDTH-1:0] cur;
  logic             lslot;
  logic             drive;
  xop_e             op;

`ifdef XBANK_LIMIT_EN
  logic [WIDTH-1:0] lim [NREG];
  assign lslot = ifc.lx | ifc.llim;
`else
  assign lslot = ifc.lx;
`endif

  assign op = xop_decode(ifc.lx, lslot, ifc.pinc, ifc.inx, ifc.dex);

  for (genvar i = 0; i < NREG; i++) begin : g_cell
    xreg_cell #(
      .WIDTH (WIDTH),
      .STEP  (STEP)
    ) u_cell (
      .clk  (clk),
      .clr  (clr),
      .op   ((ifc.sel == SEL_W'(i)) ? op : OP_HOLD),
      .din  (bus),
`ifdef XBANK_LIMIT_EN
      .ldl  (ifc.llim && (ifc.sel == SEL_W'(i))),
      .lim  (lim[i]),
`endif
      .q    (val[i]),
      .wrap (wrap[i])
    );
  end

  // A load always wins the bus, so lx with ex/pinc never self-contends.
  assign cur   = val[ifc.sel];
  assign drive = (ifc.ex | ifc.pinc) & ~ifc.lx;
  assign bus   = drive ? cur : 'z;

  assign ifc.im = cur[WIDTH-1];
  assign ifc.iz = (cur == '0);
  assign ifc.iw = wrap[ifc.sel];
`ifdef XBANK_LIMIT_EN
  assign ifc.il = (cur == lim[ifc.sel]);
`endif

endmodule

// File: tb/tb_xreg_bank.sv
// Bench for xreg_bank: directed vector tables plus randomized ops against an arithmetic reference model.
module tb_xreg_bank;

  localparam int W    = 12;
  localparam int N    = 4;
  localparam int MODV = 1 << W;
  localparam int STP  = 1;

  localparam logic [5:0] LX = 6'b100000;
  localparam logic [5:0] LL = 6'b010000;
  localparam logic [5:0] EX = 6'b001000;
  localparam logic [5:0] IN = 6'b000100;
  localparam logic [5:0] DE = 6'b000010;
  localparam logic [5:0] PI = 6'b000001;

  typedef struct {
    logic         clr;
    logic [1:0]   sel;
    logic [5:0]   ops;
    logic [W-1:0] busv;
    logic         chkb;
    logic [W-1:0] ebus;
    logic         chkf;
    logic [2:0]   ef;
    logic         chkl;
    logic         eil;
  } vec_t;

  logic         clk;
  logic         clr;
  logic         drv;
  logic [W-1:0] drv_val;
  wire  [W-1:0] bus;

  int checks   = 0;
  int failures = 0;

  int mreg [N];
  int mw   [N];
  int mlim [N];
  bit mvalid = 0;

  vec_t tbl  [$];
  vec_t ltbl [$];

  xreg_bank_if #(.NREG(N)) xif ();

  xreg_bank #(.WIDTH(W), .NREG(N), .STEP(STP)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus),
    .ifc (xif)
  );

  assign bus = drv ? drv_val : 'z;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic c, input logic [1:0] s, input logic [5:0] o,
                              input logic [W-1:0] bv, input logic cb, input logic [W-1:0] eb,
                              input logic cf, input logic [2:0] f, input logic cl, input logic l);
    vec_t v;
    v.clr = c; v.sel = s; v.ops = o; v.busv = bv; v.chkb = cb; v.ebus = eb;
    v.chkf = cf; v.ef = f; v.chkl = cl; v.eil = l;
    return v;
  endfunction

  // Reference model: plain modular arithmetic on the selected register.
  task automatic model_step(input vec_t v);
    int s;
    int t;
    s = v.sel;
    if (v.clr) begin
      for (int i = 0; i < N; i++) begin
        mreg[i] = 0; mw[i] = 0; mlim[i] = MODV - 1;
      end
      mvalid = 1;
    end else if (v.ops[5] || v.ops[4]) begin
`ifdef XBANK_LIMIT_EN
      if (v.ops[4]) mlim[s] = v.busv;
`endif
      if (v.ops[5]) begin
        mreg[s] = v.busv; mw[s] = 0;
      end
    end else if (v.ops[0] || (v.ops[2] && !v.ops[1])) begin
`ifdef XBANK_LIMIT_EN
      if (mreg[s] == mlim[s]) begin
        mreg[s] = 0; mw[s] = 1;
      end else
`endif
      begin
        t = mreg[s] + STP;
        if (t >= MODV) begin t = t - MODV; mw[s] = 1; end
        mreg[s] = t;
      end
    end else if (v.ops[1] && !v.ops[2]) begin
`ifdef XBANK_LIMIT_EN
      if (mreg[s] == 0) begin
        mreg[s] = mlim[s]; mw[s] = 1;
      end else
`endif
      begin
        t = mreg[s] - STP;
        if (t < 0) begin t = t + MODV; mw[s] = 1; end
        mreg[s] = t;
      end
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    logic dd;
    int   s;
    s  = v.sel;
    dd = (v.ops[3] | v.ops[0]) & ~v.ops[5];
    @(negedge clk);
    clr      = v.clr;
    xif.sel  = v.sel;
    xif.lx   = v.ops[5];
    xif.ex   = v.ops[3];
    xif.inx  = v.ops[2];
    xif.dex  = v.ops[1];
    xif.pinc = v.ops[0];
`ifdef XBANK_LIMIT_EN
    xif.llim = v.ops[4];
`endif
    drv      = ~dd;
    drv_val  = v.busv;
    #1;
    if (v.chkb) chk({tag, "_bus"}, int'(bus), int'(v.ebus));
    if (v.chkf) begin
      chk({tag, "_im"}, int'(xif.im), int'(v.ef[2]));
      chk({tag, "_iz"}, int'(xif.iz), int'(v.ef[1]));
      chk({tag, "_iw"}, int'(xif.iw), int'(v.ef[0]));
    end
`ifdef XBANK_LIMIT_EN
    if (v.chkl) chk({tag, "_il"}, int'(xif.il), int'(v.eil));
`endif
    if (mvalid) begin
      chk({tag, "_mbus"}, int'(bus), dd ? mreg[s] : int'(v.busv));
      chk({tag, "_mim"}, int'(xif.im), (mreg[s] >> (W - 1)) & 1);
      chk({tag, "_miz"}, int'(xif.iz), int'(mreg[s] == 0));
      chk({tag, "_miw"}, int'(xif.iw), mw[s]);
`ifdef XBANK_LIMIT_EN
      chk({tag, "_mil"}, int'(xif.il), int'(mreg[s] == mlim[s]));
`endif
    end
    @(posedge clk);
    model_step(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t rv;
    logic [5:0] o;
    clr = 1'b0; drv = 1'b1; drv_val = '0;
    xif.sel = '0; xif.lx = 0; xif.ex = 0; xif.inx = 0; xif.dex = 0; xif.pinc = 0;
`ifdef XBANK_LIMIT_EN
    xif.llim = 0;
`endif

    // clr, sel, ops, busv, chkb, ebus, chkf, {im,iz,iw}, chkl, il
    tbl.push_back(mk(1, 0, 0,       12'h000, 0, 12'h000, 0, 3'b000, 0, 0));
    tbl.push_back(mk(0, 0, EX,      12'h000, 1, 12'h000, 1, 3'b010, 0, 0));
    tbl.push_back(mk(0, 3, EX,      12'h000, 1, 12'h000, 1, 3'b010, 0, 0));
    tbl.push_back(mk(0, 2, LX,      12'h5A5, 1, 12'h5A5, 1, 3'b010, 0, 0));
    tbl.push_back(mk(0, 2, EX,      12'h000, 1, 12'h5A5, 1, 3'b000, 0, 0));
    tbl.push_back(mk(0, 1, EX,      12'h000, 1, 12'h000, 1, 3'b010, 0, 0));
    tbl.push_back(mk(0, 3, EX,      12'h000, 1, 12'h000, 1, 3'b010, 0, 0));
    tbl.push_back(mk(0, 0, EX,      12'h000, 1, 12'h000, 1, 3'b010, 0, 0));
    tbl.push_back(mk(0, 2, 0,       12'h0F0, 1, 12'h0F0, 1, 3'b000, 0, 0));
    tbl.push_back(mk(0, 1, LX,      12'hFFF, 1, 12'hFFF, 1, 3'b010, 0, 0));
    tbl.push_back(mk(0, 1, IN,      12'h000, 0, 12'h000, 1, 3'b100, 0, 0));
    tbl.push_back(mk(0, 1, EX,      12'h000, 1, 12'h000, 1, 3'b011, 0, 0));
    tbl.push_back(mk(0, 1, DE,      12'h000, 0, 12'h000, 1, 3'b011, 0, 0));
    tbl.push_back(mk(0, 1, EX,      12'h000, 1, 12'hFFF, 1, 3'b101, 0, 0));
    tbl.push_back(mk(0, 0, EX,      12'h000, 1, 12'h000, 1, 3'b010, 0, 0));
    tbl.push_back(mk(0, 1, LX,      12'h010, 1, 12'h010, 1, 3'b101, 0, 0));
    tbl.push_back(mk(0, 1, EX,      12'h000, 1, 12'h010, 1, 3'b000, 0, 0));
    tbl.push_back(mk(0, 1, IN | DE, 12'h000, 0, 12'h000, 1, 3'b000, 0, 0));
    tbl.push_back(mk(0, 1, EX,      12'h000, 1, 12'h010, 1, 3'b000, 0, 0));
    tbl.push_back(mk(0, 3, LX | EX, 12'h123, 1, 12'h123, 1, 3'b010, 0, 0));
    tbl.push_back(mk(0, 3, EX,      12'h000, 1, 12'h123, 1, 3'b000, 0, 0));
    tbl.push_back(mk(0, 0, LX,      12'h7FF, 1, 12'h7FF, 1, 3'b010, 0, 0));
    tbl.push_back(mk(0, 0, PI,      12'h000, 1, 12'h7FF, 1, 3'b000, 0, 0));
    tbl.push_back(mk(0, 0, EX,      12'h000, 1, 12'h800, 1, 3'b100, 0, 0));
    tbl.push_back(mk(1, 0, LX,      12'h555, 1, 12'h555, 1, 3'b100, 0, 0));
    tbl.push_back(mk(0, 0, EX,      12'h000, 1, 12'h000, 1, 3'b010, 0, 0));
    tbl.push_back(mk(0, 1, EX,      12'h000, 1, 12'h000, 1, 3'b010, 0, 0));
    tbl.push_back(mk(0, 2, LX,      12'h00A, 1, 12'h00A, 1, 3'b010, 0, 0));
    tbl.push_back(mk(1, 2, IN,      12'h000, 0, 12'h000, 1, 3'b000, 0, 0));
    tbl.push_back(mk(0, 2, EX,      12'h000, 1, 12'h000, 1, 3'b010, 0, 0));

    foreach (tbl[i]) apply(tbl[i], $sformatf("v%0d", i));

`ifdef XBANK_LIMIT_EN
    ltbl.push_back(mk(1, 0, 0,  12'h000, 0, 12'h000, 0, 3'b000, 0, 0));
    ltbl.push_back(mk(0, 3, LL, 12'h003, 1, 12'h003, 1, 3'b010, 1, 0));
    ltbl.push_back(mk(0, 3, IN, 12'h000, 0, 12'h000, 1, 3'b010, 1, 0));
    ltbl.push_back(mk(0, 3, IN, 12'h000, 0, 12'h000, 1, 3'b000, 1, 0));
    ltbl.push_back(mk(0, 3, IN, 12'h000, 0, 12'h000, 1, 3'b000, 1, 0));
    ltbl.push_back(mk(0, 3, EX, 12'h000, 1, 12'h003, 1, 3'b000, 1, 1));
    ltbl.push_back(mk(0, 3, IN, 12'h000, 0, 12'h000, 1, 3'b000, 1, 1));
    ltbl.push_back(mk(0, 3, EX, 12'h000, 1, 12'h000, 1, 3'b011, 1, 0));
    ltbl.push_back(mk(0, 3, DE, 12'h000, 0, 12'h000, 1, 3'b011, 1, 0));
    ltbl.push_back(mk(0, 3, EX, 12'h000, 1, 12'h003, 1, 3'b001, 1, 1));
    ltbl.push_back(mk(0, 0, EX, 12'h000, 1, 12'h000, 1, 3'b010, 1, 0));
    foreach (ltbl[i]) apply(ltbl[i], $sformatf("l%0d", i));
`endif

    // Randomized operation mix, checked only against the reference model.
    for (int n = 0; n < 600; n++) begin
      o = 6'($urandom & $urandom);
`ifndef XBANK_LIMIT_EN
      o[4] = 1'b0;
`endif
      if (o[4] && !o[5]) begin
        o[3] = 1'b0;
        o[0] = 1'b0;
      end
      rv = mk(($urandom_range(0, 31) == 0), 2'($urandom_range(0, N - 1)), o,
              W'($urandom), 0, 12'h000, 0, 3'b000, 0, 0);
      apply(rv, "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
